// File: rtl/cvxif_issue_queue_decoder_pkg.sv
// Shared types for the CV-X-IF coprocessor decoder: instruction-table entry
// layout and the opcode encoding handed to the execution unit.
package cvxif_instr_pkg;

  localparam int unsigned CoproInstrWidth = 73;

  typedef enum logic [3:0] {
    OPC_NONE  = 4'd0,
    OPC_ADD   = 4'd1,
    OPC_SUB   = 4'd2,
    OPC_MUL   = 4'd3,
    OPC_MAC   = 4'd4,
    OPC_SHIFT = 4'd5,
    OPC_LOGIC = 4'd6,
    OPC_CMP   = 4'd7
  } opcode_t;

  // Field order (MSB first) fixes the 73-bit packing of one table row.
  typedef struct packed {
    logic [31:0] match;
    logic [31:0] mask;
    logic [2:0]  rs_read;
    logic        accept;
    logic        writeback;
    opcode_t     opcode;
  } copro_instr_t;

endpackage

// File: rtl/cvxif_issue_queue_decoder_match.sv
// Combinational priority matcher over the compile-time instruction table;
// the lowest matching index wins.
module cvxif_instr_match
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned                  NbInstr    = 4,
  parameter copro_instr_t [NbInstr-1:0]   CoproInstr = '0
) (
  input  logic [31:0]  instr_i,
  output logic         hit_o,
  output copro_instr_t entry_o
);

  // Scanning from the top down lets lower indices overwrite higher ones.
  always_comb begin
    hit_o   = 1'b0;
    entry_o = '0;
    for (int i = int'(NbInstr) - 1; i >= 0; i--) begin
      if ((instr_i & CoproInstr[i].mask) == CoproInstr[i].match) begin
        hit_o   = 1'b1;
        entry_o = CoproInstr[i];
      end
    end
  end

endmodule

// File: rtl/cvxif_issue_queue_decoder.sv
// CV-X-IF issue decoder with a Depth-entry operand FIFO towards the
// coprocessor execution unit; answers the issue handshake combinationally.
module cvxif_issue_queue_decoder
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned                NbInstr     = 4,
  parameter copro_instr_t [NbInstr-1:0] CoproInstr  = '0,
  parameter int unsigned                NrRgprPorts = 2,
  parameter int unsigned                XLEN        = 32,
  parameter int unsigned                HartIdWidth = 1,
  parameter int unsigned                IdWidth     = 4,
  parameter int unsigned                Depth       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          issue_valid_i,
  input  logic [31:0]                   issue_instr_i,
  input  logic [HartIdWidth-1:0]        issue_hartid_i,
  input  logic [IdWidth-1:0]            issue_id_i,
  output logic                          issue_ready_o,
  output logic                          issue_accept_o,
  output logic                          issue_writeback_o,
  output logic [NrRgprPorts-1:0]        issue_register_read_o,
  input  logic [NrRgprPorts*XLEN-1:0]   register_i,
  input  logic [NrRgprPorts-1:0]        register_rs_valid_i,
  input  logic                          flush_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [3:0]                    out_opcode_o,
  output logic [HartIdWidth-1:0]        out_hartid_o,
  output logic [IdWidth-1:0]            out_id_o,
  output logic [4:0]                    out_rd_o,
  output logic [NrRgprPorts*XLEN-1:0]   out_rs_o,
  output logic                          out_writeback_o,
  output logic [$clog2(Depth+1)-1:0]    count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  // Entry layout depends on module parameters, so it is declared here.
  typedef struct packed {
    opcode_t                        opcode;
    logic [HartIdWidth-1:0]         hartid;
    logic [IdWidth-1:0]             id;
    logic [4:0]                     rd;
    logic [NrRgprPorts*XLEN-1:0]    rs;
    logic                           writeback;
  } queue_entry_t;

  logic                   hit;
  copro_instr_t           win;
  logic [NrRgprPorts-1:0] rs_read;
  logic                   decoded;
  logic                   operands_ok;
  logic                   full;
  logic                   out_valid;
  logic                   push;
  logic                   pop;
  logic                   unused_bits;
  queue_entry_t           new_entry;
  queue_entry_t           head;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q,  count_d;
  queue_entry_t    mem_q [Depth];

  cvxif_instr_match #(
    .NbInstr    (NbInstr),
    .CoproInstr (CoproInstr)
  ) u_match (
    .instr_i (issue_instr_i),
    .hit_o   (hit),
    .entry_o (win)
  );

  assign rs_read     = win.rs_read[NrRgprPorts-1:0];
  assign unused_bits = ^{win.match, win.mask, win.rs_read};
  assign decoded     = issue_valid_i && hit;

  assign issue_accept_o        = decoded && win.accept;
  assign issue_writeback_o     = decoded && win.writeback;
  assign issue_register_read_o = decoded ? rs_read : '0;

  assign operands_ok = &(~rs_read | register_rs_valid_i);
  assign out_valid   = (count_q != '0);
  assign full        = (count_q == CntW'(Depth));
  assign pop         = out_valid && out_ready_i;

  // A full queue still takes a new instruction when the head leaves this cycle.
  always_comb begin
    issue_ready_o = 1'b0;
    if (!flush_i) begin
      if (!hit || !win.accept) begin
        issue_ready_o = 1'b1;
      end else begin
        issue_ready_o = operands_ok && (!full || pop);
      end
    end
  end

  assign push = issue_valid_i && issue_ready_o && issue_accept_o;

  always_comb begin
    new_entry           = '0;
    new_entry.opcode    = win.opcode;
    new_entry.hartid    = issue_hartid_i;
    new_entry.id        = issue_id_i;
    new_entry.rd        = issue_instr_i[11:7];
    new_entry.writeback = win.writeback;
    for (int p = 0; p < int'(NrRgprPorts); p++) begin
      new_entry.rs[p*XLEN +: XLEN] = rs_read[p] ? register_i[p*XLEN +: XLEN] : '0;
    end
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; emptiness masks it on the outputs.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_valid_o     = out_valid;
  assign out_opcode_o    = head.opcode;
  assign out_hartid_o    = head.hartid;
  assign out_id_o        = head.id;
  assign out_rd_o        = head.rd;
  assign out_rs_o        = head.rs;
  assign out_writeback_o = head.writeback;
  assign count_o         = count_q;

endmodule

// File: tb/tb_cvxif_issue_queue_decoder.sv
// Scoreboard bench for cvxif_issue_queue_decoder: a table-lookup reference
// model predicts decode results and the FIFO contents as a plain queue.
module tb_cvxif_issue_queue_decoder;

  localparam int NRP   = 2;
  localparam int XL    = 32;
  localparam int DEPTH = 4;

  localparam logic [31:0] T_MATCH [4] = '{32'h0000000B, 32'h0000002B, 32'h0000005B, 32'h0000002B};
  localparam logic [31:0] T_MASK  [4] = '{32'h0000707F, 32'h0000707F, 32'h0000007F, 32'h0000007F};
  localparam logic [2:0]  T_RS    [4] = '{3'b011, 3'b001, 3'b111, 3'b110};
  localparam logic        T_ACC   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic        T_WB    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [3:0]  T_OPC   [4] = '{4'd1, 4'd2, 4'd4, 4'd5};

  localparam logic [4*73-1:0] TABLE = {
    T_MATCH[3], T_MASK[3], T_RS[3], T_ACC[3], T_WB[3], T_OPC[3],
    T_MATCH[2], T_MASK[2], T_RS[2], T_ACC[2], T_WB[2], T_OPC[2],
    T_MATCH[1], T_MASK[1], T_RS[1], T_ACC[1], T_WB[1], T_OPC[1],
    T_MATCH[0], T_MASK[0], T_RS[0], T_ACC[0], T_WB[0], T_OPC[0]};

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              issue_valid_i;
  logic [31:0]       issue_instr_i;
  logic [0:0]        issue_hartid_i;
  logic [3:0]        issue_id_i;
  logic              issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [NRP-1:0]    issue_register_read_o;
  logic [NRP*XL-1:0] register_i;
  logic [NRP-1:0]    register_rs_valid_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [3:0]        out_opcode_o;
  logic [0:0]        out_hartid_o;
  logic [3:0]        out_id_o;
  logic [4:0]        out_rd_o;
  logic [NRP*XL-1:0] out_rs_o;
  logic              out_writeback_o;
  logic [2:0]        count_o;

  typedef struct {
    logic [3:0]  opc;
    logic        hid;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [63:0] rs;
    logic        wb;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  cvxif_issue_queue_decoder #(
    .NbInstr(4), .CoproInstr(TABLE), .NrRgprPorts(NRP), .XLEN(XL),
    .HartIdWidth(1), .IdWidth(4), .Depth(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_instr_i(issue_instr_i),
    .issue_hartid_i(issue_hartid_i), .issue_id_i(issue_id_i),
    .issue_ready_o(issue_ready_o), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o), .issue_register_read_o(issue_register_read_o),
    .register_i(register_i), .register_rs_valid_i(register_rs_valid_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_opcode_o(out_opcode_o), .out_hartid_o(out_hartid_o), .out_id_o(out_id_o),
    .out_rd_o(out_rd_o), .out_rs_o(out_rs_o), .out_writeback_o(out_writeback_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int lookup(input logic [31:0] instr);
    for (int i = 0; i < 4; i++)
      if ((instr & T_MASK[i]) == T_MATCH[i]) return i;
    return -1;
  endfunction

  // Drive one cycle of inputs, then check the same-cycle decode against the model.
  task automatic apply_stimulus(input bit v, input logic [31:0] instr, input logic hid,
                                input logic [3:0] id, input logic [63:0] regs,
                                input logic [1:0] rsv, input bit fl, input bit rdy);
    int   idx, sz0;
    bit   acc, wb, ok, rdy_exp;
    logic [1:0] rr;
    exp_t e;
    @(posedge clk_i); #1;
    issue_valid_i = v; issue_instr_i = instr; issue_hartid_i = hid; issue_id_i = id;
    register_i = regs; register_rs_valid_i = rsv; flush_i = fl; out_ready_i = rdy;
    sz0 = exp_q.size();
    @(negedge clk_i); #1;
    idx = lookup(instr);
    acc = 0; wb = 0; rr = 2'b00; ok = 1;
    if (idx >= 0) begin
      acc = T_ACC[idx]; wb = T_WB[idx]; rr = T_RS[idx][1:0];
      ok  = (!rr[0] || rsv[0]) && (!rr[1] || rsv[1]);
    end
    if (fl)               rdy_exp = 0;
    else if (idx < 0)     rdy_exp = 1;
    else if (!acc)        rdy_exp = 1;
    else                  rdy_exp = ok && (sz0 < DEPTH || (rdy && sz0 > 0));
    if (v) begin
      check_output("issue_ready", issue_ready_o, rdy_exp);
      check_output("issue_accept", issue_accept_o, acc);
      check_output("issue_writeback", issue_writeback_o, wb);
      check_output("issue_register_read", issue_register_read_o, rr);
    end else begin
      check_output("idle_decode", {issue_accept_o, issue_writeback_o, issue_register_read_o}, 0);
    end
    if (v && rdy_exp && acc) begin
      e.opc = T_OPC[idx]; e.hid = hid; e.id = id; e.rd = instr[11:7]; e.wb = wb;
      e.rs  = {rr[1] ? regs[63:32] : 32'h0, rr[0] ? regs[31:0] : 32'h0};
      exp_q.push_back(e);
    end
    if (fl) exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    issue_valid_i = 0; flush_i = 0; out_ready_i = 0;
    rst_ni = 0;
    #1;
    check_output("reset_count", count_o, 0);
    check_output("reset_out_valid", out_valid_o, 0);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) apply_stimulus(0, 32'h0, 0, 4'h0, 64'h0, 2'b00, 0, rdy);
  endtask

  // Monitor: occupancy, head visibility and in-order delivery on every pop.
  initial begin
    int   sz;
    exp_t e;
    forever begin
      @(negedge clk_i);
      sz = exp_q.size();
      check_output("count", count_o, sz);
      check_output("out_valid", out_valid_o, sz != 0);
      if (sz == 0) begin
        check_output("empty_out_zero",
          |{out_opcode_o, out_hartid_o, out_id_o, out_rd_o, out_rs_o, out_writeback_o}, 0);
      end else if (out_ready_i) begin
        e = exp_q.pop_front();
        check_output("out_opcode", out_opcode_o, e.opc);
        check_output("out_hartid", out_hartid_o, e.hid);
        check_output("out_id", out_id_o, e.id);
        check_output("out_rd", out_rd_o, e.rd);
        check_output("out_rs", out_rs_o, e.rs);
        check_output("out_writeback", out_writeback_o, e.wb);
      end
    end
  end

  initial begin
    logic [31:0] instr;
    logic [6:0]  opc_pool [5];
    opc_pool = '{7'h0B, 7'h2B, 7'h5B, 7'h33, 7'h00};
    rst_ni = 1; issue_valid_i = 0; issue_instr_i = 0; issue_hartid_i = 0; issue_id_i = 0;
    register_i = 0; register_rs_valid_i = 0; flush_i = 0; out_ready_i = 0;
    #2 rst_ni = 0;
    #1;
    check_output("por_count", count_o, 0);
    check_output("por_out_valid", out_valid_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;

    // Basic accepted instruction, then drain it.
    apply_stimulus(1, 32'h0020818B, 0, 4'h1, {32'h22, 32'h11}, 2'b11, 0, 0);
    idle(2, 1);

    // rs2 missing holds ready low until its valid bit rises.
    repeat (3) apply_stimulus(1, 32'h0020818B, 1, 4'h2, {32'h44, 32'h33}, 2'b01, 0, 0);
    apply_stimulus(1, 32'h0020818B, 1, 4'h2, {32'h44, 32'h33}, 2'b11, 0, 0);
    idle(2, 1);

    // Fill to Depth, block a 5th, then accept it alongside a pop.
    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(1, 32'h0000008B | (i << 7), i[0], 4'(i + 3), {32'(i + 100), 32'(i + 200)}, 2'b11, 0, 0);
    apply_stimulus(1, 32'h0000058B, 0, 4'hA, {32'hAAAA, 32'hBBBB}, 2'b11, 0, 0);
    apply_stimulus(1, 32'h0000058B, 0, 4'hA, {32'hAAAA, 32'hBBBB}, 2'b11, 0, 1);
    apply_stimulus(1, 32'h00000033, 0, 4'hB, 64'h0, 2'b11, 0, 0);
    idle(DEPTH + 1, 1);

    // Overlapping entries: lowest index wins, then the higher entry alone.
    apply_stimulus(1, 32'h0000032B, 1, 4'hC, {32'h5, 32'h6}, 2'b11, 0, 1);
    apply_stimulus(1, 32'h0000132B, 0, 4'hD, {32'h7, 32'h8}, 2'b11, 0, 1);
    apply_stimulus(1, 32'h0000005B, 0, 4'hE, 64'h0, 2'b00, 0, 1);
    idle(2, 1);

    // Flush with a concurrent matching issue.
    for (int i = 0; i < 3; i++)
      apply_stimulus(1, 32'h0000000B, 0, 4'(i), {32'h1, 32'h2}, 2'b11, 0, 0);
    apply_stimulus(1, 32'h0000000B, 0, 4'h9, {32'h1, 32'h2}, 2'b11, 1, 0);
    idle(2, 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++)
      apply_stimulus(1, 32'h0000000B, 1, 4'(i), {32'h3, 32'h4}, 2'b11, 0, 0);
    do_reset();
    idle(2, 1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      instr[6:0] = opc_pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) instr[14:12] = 3'b000;
      apply_stimulus($urandom_range(0, 3) != 0, instr, 1'($urandom), 4'($urandom),
                     {32'($urandom), 32'($urandom)}, 2'($urandom),
                     $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end
    idle(DEPTH + 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
